// File: rtl/fas_freq_analyzer.sv
// FAS analysis stage: captures one 16-bin FFT frame and finds the bin
// with the largest squared magnitude, scanning LANES bins per cycle.
module fas_freq_analyzer #(
    parameter int LANES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fft_valid,
    input  logic [31:0] fft_d0,
    input  logic [31:0] fft_d1,
    input  logic [31:0] fft_d2,
    input  logic [31:0] fft_d3,
    input  logic [31:0] fft_d4,
    input  logic [31:0] fft_d5,
    input  logic [31:0] fft_d6,
    input  logic [31:0] fft_d7,
    input  logic [31:0] fft_d8,
    input  logic [31:0] fft_d9,
    input  logic [31:0] fft_d10,
    input  logic [31:0] fft_d11,
    input  logic [31:0] fft_d12,
    input  logic [31:0] fft_d13,
    input  logic [31:0] fft_d14,
    input  logic [31:0] fft_d15,
    output logic        done,
    output logic [3:0]  freq,
    output logic        busy,
    output logic        overrun
);

    localparam int STEPS = 16 / LANES;
    localparam logic [3:0] LAST = 4'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state, nxt;
    logic [31:0] in_bins [16];
    logic [31:0] bank    [16];
    logic [3:0]  scan_cnt, max_idx, lane_idx, win_idx, base, idx;
    logic [31:0] max_mag, lane_mag, m;
    logic        cap, last, lane_wins, ovr_d;

    assign in_bins[0]  = fft_d0;
    assign in_bins[1]  = fft_d1;
    assign in_bins[2]  = fft_d2;
    assign in_bins[3]  = fft_d3;
    assign in_bins[4]  = fft_d4;
    assign in_bins[5]  = fft_d5;
    assign in_bins[6]  = fft_d6;
    assign in_bins[7]  = fft_d7;
    assign in_bins[8]  = fft_d8;
    assign in_bins[9]  = fft_d9;
    assign in_bins[10] = fft_d10;
    assign in_bins[11] = fft_d11;
    assign in_bins[12] = fft_d12;
    assign in_bins[13] = fft_d13;
    assign in_bins[14] = fft_d14;
    assign in_bins[15] = fft_d15;

    // Each square is at most 2^30, so the unsigned sum fits in 32 bits.
    function automatic logic [31:0] mag_of(input logic [31:0] b);
        logic signed [31:0] re, im;
        re = {{16{b[31]}}, b[31:16]};
        im = {{16{b[15]}}, b[15:0]};
        return $unsigned(re * re) + $unsigned(im * im);
    endfunction

    assign last = (scan_cnt == LAST);

    always_comb begin
        base     = 4'(scan_cnt * 4'(LANES));
        idx      = base;
        m        = '0;
        lane_mag = '0;
        lane_idx = base;
        // Ascending order with strict compare keeps the lowest index on ties.
        for (int i = 0; i < LANES; i++) begin
            idx = base + 4'(i);
            m   = mag_of(bank[idx]);
            if (i == 0 || m > lane_mag) begin
                lane_mag = m;
                lane_idx = idx;
            end
        end
        lane_wins = (lane_mag > max_mag);
        win_idx   = lane_wins ? lane_idx : max_idx;
    end

    always_comb begin
        nxt   = state;
        cap   = 1'b0;
        ovr_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (fft_valid) begin
                    cap = 1'b1;
                    nxt = SCAN;
                end
            end
            SCAN: begin
                ovr_d = fft_valid;
                if (last) nxt = DONE;
            end
            DONE: begin
                if (fft_valid) begin
                    cap = 1'b1;
                    nxt = SCAN;
                end else begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            done    <= 1'b0;
            freq    <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= nxt;
            done    <= (nxt == DONE);
            busy    <= (nxt == SCAN);
            overrun <= ovr_d;
            if (state == SCAN && last) freq <= win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && cap) begin
            for (int k = 0; k < 16; k++) bank[k] <= in_bins[k];
            scan_cnt <= '0;
            max_mag  <= '0;
            max_idx  <= '0;
        end else if (state == SCAN) begin
            scan_cnt <= scan_cnt + 4'd1;
            if (lane_wins) begin
                max_mag <= lane_mag;
                max_idx <= lane_idx;
            end
        end
    end

endmodule

// File: tb/tb_fas_freq_analyzer.sv
// Scoreboard bench for fas_freq_analyzer: three lane variants share the
// frame data; a negedge monitor pops expected done/overrun events.
module tb_fas_freq_analyzer;

    typedef struct {
        logic [3:0] f;
        int         c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v1 = 1'b0, v2 = 1'b0, v4 = 1'b0;
    logic [31:0] d [16];
    logic        done1, done2, done4;
    logic [3:0]  freq1, freq2, freq4;
    logic        busy1, busy2, busy4;
    logic        ovr1, ovr2, ovr4;

    int   ecnt = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q1[$], q2[$], q4[$];
    int   oq[$];

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    fas_freq_analyzer #(.LANES(1)) u1 (
        .clk(clk), .rst(rst), .fft_valid(v1),
        .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
        .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
        .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
        .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
        .done(done1), .freq(freq1), .busy(busy1), .overrun(ovr1)
    );

    fas_freq_analyzer #(.LANES(2)) u2 (
        .clk(clk), .rst(rst), .fft_valid(v2),
        .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
        .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
        .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
        .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
        .done(done2), .freq(freq2), .busy(busy2), .overrun(ovr2)
    );

    fas_freq_analyzer #(.LANES(4)) u4 (
        .clk(clk), .rst(rst), .fft_valid(v4),
        .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
        .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
        .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
        .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
        .done(done4), .freq(freq4), .busy(busy4), .overrun(ovr4)
    );

    // Cycle label k = the cycle ending at posedge k.
    function automatic int lbl();
        return ecnt + 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, lbl());
        end
    endtask

    task automatic pop_done(input string name, ref exp_t q[$],
                            input logic [3:0] f);
        exp_t e;
        if (q.size() == 0) begin
            chk({name, "_unexpected_done"}, 1, 0);
        end else begin
            e = q.pop_front();
            chk({name, "_freq"}, int'(f), int'(e.f));
            chk({name, "_done_cycle"}, lbl(), e.c);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (done1) pop_done("l1", q1, freq1);
            if (done2) pop_done("l2", q2, freq2);
            if (done4) pop_done("l4", q4, freq4);
            if (ovr2) begin
                if (oq.size() == 0) chk("l2_unexpected_overrun", 1, 0);
                else chk("l2_overrun_cycle", lbl(), oq.pop_front());
            end
            if (ovr1 || ovr4) chk("l1_l4_overrun", 1, 0);
        end
    end

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 16; i++) d[i] = v;
    endtask

    task automatic step_to(input int t);
        while (lbl() < t) @(negedge clk);
    endtask

    // Called at a negedge; valid is seen by the next posedge (cycle lbl()).
    task automatic issue(input bit a1, input bit a2, input bit a4,
                         input bit push, input logic [3:0] f);
        int t;
        t = lbl();
        v1 = a1;
        v2 = a2;
        v4 = a4;
        if (push) begin
            if (a1) q1.push_back('{f, t + 17});
            if (a2) q2.push_back('{f, t + 9});
            if (a4) q4.push_back('{f, t + 5});
        end
        @(negedge clk);
        v1 = 1'b0;
        v2 = 1'b0;
        v4 = 1'b0;
    endtask

    task automatic peak_frame();
        fill(32'h0010_0010);
        d[1] = 32'h0400_0000;
    endtask

    task automatic tie_frame();
        fill('0);
        d[3]  = 32'h0100_FF00;
        d[12] = 32'h0100_FF00;
    endtask

    task automatic corner_frame();
        fill('0);
        d[14] = 32'h7FFF_7FFF;
        d[15] = 32'h8000_8000;
    endtask

    initial begin
        int t;
        fill('0);
        repeat (3) @(negedge clk);
        chk("rst_done", int'(done2), 0);
        chk("rst_freq", int'(freq2), 0);
        chk("rst_busy", int'(busy2), 0);
        chk("rst_overrun", int'(ovr2), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        peak_frame();
        t = lbl();
        issue(1, 1, 1, 1, 4'd1);
        for (int k = 1; k <= 8; k++) begin
            chk("peak_busy_high", int'(busy2), 1);
            @(negedge clk);
        end
        chk("peak_busy_low", int'(busy2), 0);
        step_to(t + 20);

        tie_frame();
        issue(0, 1, 0, 1, 4'd3);
        repeat (12) @(negedge clk);

        fill('0);
        issue(0, 1, 0, 1, 4'd0);
        repeat (12) @(negedge clk);

        corner_frame();
        issue(0, 1, 0, 1, 4'd15);
        repeat (12) @(negedge clk);

        peak_frame();
        t = lbl();
        issue(0, 1, 0, 1, 4'd1);
        step_to(t + 4);
        tie_frame();
        oq.push_back(t + 5);
        issue(0, 1, 0, 0, 4'd0);
        step_to(t + 14);

        corner_frame();
        t = lbl();
        issue(0, 1, 0, 1, 4'd15);
        step_to(t + 9);
        chk("b2b_done_seen", int'(done2), 1);
        tie_frame();
        issue(0, 1, 0, 1, 4'd3);
        step_to(t + 22);

        peak_frame();
        t = lbl();
        issue(0, 1, 0, 0, 4'd0);
        step_to(t + 5);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_freq", int'(freq2), 0);
        chk("midrst_busy", int'(busy2), 0);
        chk("midrst_overrun", int'(ovr2), 0);
        chk("midrst_done", int'(done2), 0);
        repeat (14) @(negedge clk);

        t = lbl();
        while ((q1.size() + q2.size() + q4.size() + oq.size()) != 0
               && lbl() < t + 40)
            @(negedge clk);
        chk("pending_done", q1.size() + q2.size() + q4.size(), 0);
        chk("pending_overrun", oq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fas_freq_analyzer.md
# fas_freq_analyzer

Analysis stage that sits directly downstream of the FFT in the FAS datapath. It captures one 16-bin FFT frame when `fft_valid` is asserted and computes the squared magnitude of every bin. It reports the index of the largest bin on `freq`, qualified by a single-cycle `done` pulse. It is the block that drives the FAS `done`/`freq` outputs.

## Interface
- `LANES`, default 2: bins evaluated per scan cycle. Legal values are 1, 2 and 4. Scan length is 16/`LANES` cycles.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-low reset. It is sampled on the rising edge of `clk`.
- `fft_valid` input 1: frame strobe. `fft_d0`..`fft_d15` are valid in the cycle it is high.
- `fft_d0`..`fft_d15` input 32 each: bin k is `{real[31:16], imag[15:0]}`. Both halves are signed two's complement, 8.8 fixed point.
- `done` output 1: one-cycle pulse marking `freq` as freshly updated.
- `freq` output 4: index (0–15) of the largest-magnitude bin of the last completed frame.
- `busy` output 1: high while a captured frame is being scanned.
- `overrun` output 1: one-cycle pulse when a frame is dropped.

## Operation
- **Capture register bank:** 16 × 32 bits, loaded from `fft_d0`..`fft_d15` when a frame is accepted.
- **Magnitude:** `mag = re*re + im*im`.
  - Computed as signed 16×16 products, each at most 2^30.
  - The sum is held as a 32-bit unsigned value, at most 2^31, so it never overflows. No truncation or rounding is applied.
  - The fractional scaling is irrelevant for the comparison and is ignored.
- **State machine:** IDLE, SCAN, DONE.
  - IDLE: `busy`=0. If `fft_valid`=1, capture the frame, clear `scan_cnt` and the running max, then go to SCAN.
  - SCAN: `busy`=1.
    - Each cycle evaluates bins `scan_cnt*LANES` … `scan_cnt*LANES+LANES-1`.
    - The lanes are first reduced among themselves, with the lower index winning ties.
    - The lane winner replaces the running max only if its magnitude is strictly greater.
    - After the group containing bin 15, go to DONE.
  - DONE: `done`=1 for exactly this cycle and `freq` presents the winner.
    - If `fft_valid`=1 in this cycle, capture the new frame and go directly to SCAN (back-to-back frames).
    - Otherwise go to IDLE.
- **Running max initial value:** magnitude 0, index 0. An all-zero frame therefore reports `freq`=0.
- **Tie rule:** the lowest index holding the maximum always wins, both across cycles and within a cycle.
- **Overrun:**
  - `fft_valid`=1 while in SCAN drops the new frame. `overrun` pulses in the following cycle.
  - The in-flight scan continues unaffected and the capture bank is not written.
- **`freq` hold:** `freq` is a register. It changes only on entry to DONE and holds between frames.

## Timing
- **Reset values** (first edge with `rst`=0): state IDLE, `done`=0, `freq`=0, `busy`=0, `overrun`=0.
  - The capture bank and running max need not be reset.
- **Reset mid-SCAN:** the scan aborts with no `done`, and `freq` returns to 0.
- **Latency** (`fft_valid` sampled at edge T):
  - `busy` is high from T+1 through the end of the last scan cycle.
  - The SCAN cycles are T+1 … T+16/`LANES`.
  - `done` and the new `freq` are visible in cycle T+16/`LANES`+1. With `LANES`=2 this is T+9.
- **Throughput:** back-to-back frames via the DONE state give one frame per 16/`LANES`+1 cycles.
  - With `LANES`=2 (9 cycles) this is below the 16-cycle FFT frame period, so no overruns occur in the normal flow.
- **Registered outputs:** `done`, `freq`, `busy` and `overrun` all come from flops with no combinational input→output path.
- **Simultaneous events:** if `rst`=0 and `fft_valid`=1 in the same cycle, reset wins and the frame is not captured.

## Test plan
- **Single peak:** bin 1 = {0x0400, 0x0000}, all others {0x0010, 0x0010}, `fft_valid` pulsed at T → `done`=1 and `freq`=1 in cycle T+9 only. `busy`=1 for T+1..T+8.
- **Tie:** bins 3 and 12 = {0x0100, 0xFF00}, all others zero → `freq`=3.
- **Corner magnitudes:**
  - All-zero frame → `freq`=0 with `done` pulsed.
  - Bin 15 = {0x8000, 0x8000} (magnitude 2^31) with bin 14 = {0x7FFF, 0x7FFF} → `freq`=15, showing no overflow.
- **Overrun and back-to-back:**
  - A second `fft_valid` at T+4 → `overrun` pulses at T+5, the result is from the first frame, and only one `done` occurs.
  - `fft_valid` in the DONE cycle T+9 → the second `done` arrives at T+18 with that frame's index.
- **Reset:** `rst` low at T+5 during SCAN → no `done`, and `freq`=0, `busy`=0, `overrun`=0 from T+6.
- **Lane variants:** repeat the single-peak frame with `LANES`=1 and `LANES`=4 → `done` at T+17 and T+5 respectively, with an identical `freq`.
